// File: rtl/traffic_phase_scheduler.sv
// Tick-timed highway/normal-road phase sequencer with latched car and pedestrian requests.
// Lamps and phase decode straight from the registered state, so they move on the state edge.
module traffic_phase_scheduler #(
  parameter int TICK_DIV       = 4,
  parameter int HWY_MIN_GREEN  = 8,
  parameter int NORM_MIN_GREEN = 4,
  parameter int NORM_MAX_GREEN = 12,
  parameter int YELLOW_TICKS   = 3,
  parameter int ALLRED_TICKS   = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       in,
  input  logic       ped_req,
  output logic [2:0] hwy,
  output logic [2:0] normal,
  output logic       walk,
  output logic [2:0] phase
);

  localparam logic [2:0] S_HG  = 3'd0;
  localparam logic [2:0] S_HY  = 3'd1;
  localparam logic [2:0] S_AR1 = 3'd2;
  localparam logic [2:0] S_NG  = 3'd3;
  localparam logic [2:0] S_NY  = 3'd4;
  localparam logic [2:0] S_AR2 = 3'd5;

  localparam logic [2:0] L_RED    = 3'b100;
  localparam logic [2:0] L_GREEN  = 3'b010;
  localparam logic [2:0] L_YELLOW = 3'b001;

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  // Last phase_cnt value of each dwell; the exit happens on the tick that sees it.
  localparam logic [7:0] HG_LAST     = 8'(HWY_MIN_GREEN - 1);
  localparam logic [7:0] NG_MIN_LAST = 8'(NORM_MIN_GREEN - 1);
  localparam logic [7:0] NG_MAX_LAST = 8'(NORM_MAX_GREEN - 1);
  localparam logic [7:0] Y_LAST      = 8'(YELLOW_TICKS - 1);
  localparam logic [7:0] AR_LAST     = 8'(ALLRED_TICKS - 1);

  logic [2:0]    r_state;
  logic [2:0]    w_next;
  logic [PW-1:0] r_presc;
  logic [7:0]    r_cnt;
  logic          r_car_pend;
  logic          r_ped_pend;
  logic          r_walk_en;
  logic          w_tick;
  logic          w_chg;
  logic          w_enter_ng;
  logic          w_leave_ng;

  assign w_tick     = (r_presc == PRESC_LAST);
  assign w_chg      = (w_next != r_state);
  assign w_enter_ng = w_chg && (w_next == S_NG);
  assign w_leave_ng = w_chg && (r_state == S_NG);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_HG;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_HG:  if (w_tick && (r_cnt >= HG_LAST) && (r_car_pend || r_ped_pend || in)) w_next = S_HY;
      S_HY:  if (w_tick && (r_cnt == Y_LAST)) w_next = S_AR1;
      S_AR1: if (w_tick && (r_cnt == AR_LAST)) w_next = S_NG;
      S_NG:  if (w_tick && ((r_cnt >= NG_MAX_LAST) || ((r_cnt >= NG_MIN_LAST) && !in))) w_next = S_NY;
      S_NY:  if (w_tick && (r_cnt == Y_LAST)) w_next = S_AR2;
      S_AR2: if (w_tick && (r_cnt == AR_LAST)) w_next = S_HG;
      default: w_next = S_HG;
    endcase
  end

  always_comb begin
    hwy    = L_RED;
    normal = L_RED;
    walk   = 1'b0;
    phase  = r_state;
    case (r_state)
      S_HG: hwy = L_GREEN;
      S_HY: hwy = L_YELLOW;
      S_NG: begin
        normal = L_GREEN;
        walk   = r_walk_en;
      end
      S_NY: normal = L_YELLOW;
      default: ;
    endcase
  end

  // Clears on NG entry take precedence over same-edge sets; a ped_req on that edge re-arms ped_pend.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_presc    <= '0;
      r_cnt      <= 8'd0;
      r_car_pend <= 1'b0;
      r_ped_pend <= 1'b0;
      r_walk_en  <= 1'b0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + PW'(1);

      if (w_chg) begin
        r_cnt <= 8'd0;
      end else if (w_tick && (r_cnt != 8'hFF)) begin
        r_cnt <= r_cnt + 8'd1;
      end

      if (w_enter_ng) begin
        r_car_pend <= 1'b0;
      end else if (in && (r_state != S_NG)) begin
        r_car_pend <= 1'b1;
      end

      if (w_enter_ng) begin
        r_ped_pend <= ped_req;
      end else if (ped_req) begin
        r_ped_pend <= 1'b1;
      end

      if (w_enter_ng) begin
        r_walk_en <= r_ped_pend;
      end else if (w_leave_ng) begin
        r_walk_en <= 1'b0;
      end
    end
  end

endmodule
